jk_sync_counter: RTL and testbench

JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

---
 rtl/jk_sync_counter.sv | 95 +++++++++
 tb/tb_jk_sync_counter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jk_sync_counter.sv
// rtl/jk_sync_counter.sv - modulo up/down counter built from per-bit JK cells
//
// Each count bit is a JK flip-flop. A single "target" value is chosen by
// clear > load > en > hold, and the J/K pair of every bit is derived from
// that choice and the current count: counting toggles the bits that change,
// clear resets them, load sets/resets them, and hold leaves J=K=0.
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Terminal values; MOD_C carries one extra bit so MODULUS = 2**WIDTH fits.
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_C = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] j, k;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;

  // Terminal-count detection; tc is a pure function of inputs and count.
  always_comb begin
    at_max  = (count_q == MAX_C);
    at_zero = (count_q == '0);
    tc      = en & ((up & at_max) | (~up & at_zero));
  end

  // Candidate values for the count and load paths.
  always_comb begin
    if (up) begin
      step_val = at_max ? '0 : count_q + 1'b1;
    end else begin
      step_val = at_zero ? MAX_C : count_q - 1'b1;
    end
    load_sat = ({1'b0, load_val} >= MOD_C) ? MAX_C : load_val;
  end

  // J/K selection by priority; only a counting edge can report a wrap.
  always_comb begin
    j      = '0;
    k      = '0;
    wrap_d = 1'b0;
    if (clear) begin
      k = '1;
    end else if (load) begin
      j = load_sat;
      k = ~load_sat;
    end else if (en) begin
      j      = count_q ^ step_val;
      k      = count_q ^ step_val;
      wrap_d = tc;
    end
  end

  // JK cell behaviour for every bit: toggle, set, clear or hold.
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b11:   count_d[i] = ~count_q[i];
        2'b10:   count_d[i] = 1'b1;
        2'b01:   count_d[i] = 1'b0;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // State registers with asynchronous reset to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// tb/tb_jk_sync_counter.sv - scoreboard bench for jk_sync_counter
module tb_jk_sync_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;

  jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
    .load(load), .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit w;
  } exp_t;

  exp_t exp_q[$];
  bit   tc_q[$];
  int   checks = 0;
  int   failures = 0;
  int   m_count = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Post-edge monitor: count and wrap after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count", int'(count), e.cnt);
        chk("wrap", int'(wrap), int'(e.w));
      end
    end
  end

  // Pre-edge monitor: combinational tc after inputs settle.
  initial begin
    bit t;
    forever begin
      @(negedge clk);
      #2;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        chk("tc", int'(tc), int'(t));
      end
    end
  end

  // One clock of stimulus plus the reference model's prediction.
  task automatic step(input bit r, input bit e, input bit u, input bit c,
                      input bit l, input int lv);
    int   nc;
    bit   w;
    exp_t x;
    @(negedge clk);
    reset    = r;
    en       = e;
    up       = u;
    clear    = c;
    load     = l;
    load_val = W'(lv);
    if (r) m_count = 0;
    tc_q.push_back(e && ((u && m_count == M - 1) || (!u && m_count == 0)));
    w  = 1'b0;
    nc = m_count;
    if (r) nc = 0;
    else if (c) nc = 0;
    else if (l) nc = (lv >= M) ? M - 1 : lv;
    else if (e) begin
      if (u) begin
        nc = (m_count + 1) % M;
        w  = (m_count == M - 1);
      end else begin
        nc = (m_count + M - 1) % M;
        w  = (m_count == 0);
      end
    end
    m_count = nc;
    x.cnt = nc;
    x.w   = w;
    exp_q.push_back(x);
  endtask

  // Reset asserted between edges must clear the count immediately.
  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    reset = 1'b1;
    en    = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    #1;
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    m_count = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit r, e, u, c, l;
    #1;
    reset = 1'b1;
    en    = 1'b1;
    up    = 1'b1;
    #1;
    chk("reset_immediate_count", int'(count), 0);
    chk("reset_immediate_wrap", int'(wrap), 0);

    // Reset held ~100 ns with counting requested.
    repeat (10) step(1, 1, 1, 0, 0, 0);
    // Up count through the wrap.
    repeat (10) step(0, 1, 1, 0, 0, 0);
    // Down from 0 wraps to 9.
    step(0, 1, 0, 0, 0, 0);
    // Load saturation, plain load, clear over load.
    step(0, 0, 1, 0, 1, 12);
    step(0, 0, 1, 0, 1, 5);
    step(0, 1, 1, 1, 1, 5);
    // Hold at 6 then count down once.
    step(0, 0, 1, 0, 1, 6);
    repeat (5) step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Asynchronous reset at count 7.
    step(0, 0, 1, 0, 1, 7);
    async_reset_pulse();
    step(0, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 31) == 0);
      c = ($urandom_range(0, 15) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) != 0;
      step(r, e, u, c, l, int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size() + tc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
